coax_tx_arbiter: RTL and testbench

Two-requester frame arbiter that shares one `coax_tx` transmitter between independent 10-bit word streams (host command path and auto-response path). It grants the transmitter to one requester for a whole frame, feeds words into `coax_tx` one strobe at a time, waits for the line to go idle, and enforces an inter-frame gap. Frames are never interleaved; grants alternate round-robin when both requesters are waiting.

---
 rtl/coax_pkg.sv | 19 +
 rtl/coax_tx_arbiter_if.sv | 27 ++
 rtl/coax_rr_pick.sv | 21 ++
 rtl/coax_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_coax_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/coax_pkg.sv
// rtl/coax_pkg.sv - shared word width, arbiter state encodings and grant helper
package coax_pkg;

    localparam int COAX_WORD_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_t;

    // Requester index to one-hot grant vector
    function automatic logic [1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/coax_tx_arbiter_if.sv
// rtl/coax_tx_arbiter_if.sv - requester streams and coax_tx link grouped for the arbiter
interface coax_tx_arbiter_if;
    import coax_pkg::*;

    logic [1:0][COAX_WORD_WIDTH-1:0] req_data;
    logic [1:0]                      req_valid;
    logic [1:0]                      req_last;
    logic [1:0]                      req_ready;
    logic [1:0]                      grant;
    logic                            underrun;
    logic                            busy;
    logic [COAX_WORD_WIDTH-1:0]      tx_data;
    logic                            tx_strobe;
    logic                            tx_ready;
    logic                            tx_active;

    modport slave (
        input  req_data, req_valid, req_last, tx_ready, tx_active,
        output req_ready, grant, underrun, busy, tx_data, tx_strobe
    );

    modport master (
        output req_data, req_valid, req_last, tx_ready, tx_active,
        input  req_ready, grant, underrun, busy, tx_data, tx_strobe
    );

endinterface

// File: rtl/coax_rr_pick.sv
// rtl/coax_rr_pick.sv - combinational two-way round-robin picker
module coax_rr_pick
    import coax_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] pick_o
);

    // On a tie the requester that was not served last wins
    always_comb begin
        pick_o = 2'b00;
        case (valid_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = onehot_of(~last_grant_i);
            default: pick_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/coax_tx_arbiter.sv
// rtl/coax_tx_arbiter.sv - frame-granular two-requester arbiter in front of coax_tx
module coax_tx_arbiter
    import coax_pkg::*;
#(
    parameter int GAP_CLOCKS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    coax_tx_arbiter_if.slave  bus
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CLOCKS - 1);

    arb_state_t                 state_q, state_d;
    logic [1:0]                 grant_q, grant_d;
    logic                       last_grant_q, last_grant_d;
    logic [7:0]                 gap_q, gap_d;
    logic                       drain_q, drain_d;
    logic [COAX_WORD_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                       tx_strobe_q, tx_strobe_d;
    logic                       underrun_q, underrun_d;
    logic [1:0]                 req_ready_c;

    logic [1:0]                 pick;
    logic                       sel_valid;
    logic                       sel_last;
    logic [COAX_WORD_WIDTH-1:0] sel_data;

    coax_rr_pick u_pick (
        .valid_i      (bus.req_valid),
        .last_grant_i (last_grant_q),
        .pick_o       (pick)
    );

    assign sel_valid = |(bus.req_valid & grant_q);
    assign sel_last  = |(bus.req_last & grant_q);
    assign sel_data  = grant_q[1] ? bus.req_data[1] : bus.req_data[0];

    // State and output registers; reset drops the strobe and grant immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            gap_q        <= 8'd0;
            drain_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_strobe_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            gap_q        <= gap_d;
            drain_q      <= drain_d;
            tx_data_q    <= tx_data_d;
            tx_strobe_q  <= tx_strobe_d;
            underrun_q   <= underrun_d;
        end
    end

    // Next-state logic: grant a whole frame, feed words, drain the line, then gap
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        gap_d        = gap_q;
        drain_d      = 1'b0;
        tx_data_d    = tx_data_q;
        tx_strobe_d  = 1'b0;
        underrun_d   = 1'b0;
        req_ready_c  = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    grant_d = pick;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // A word is only taken when the previous strobe has retired
                if (bus.tx_ready && !tx_strobe_q) begin
                    if (sel_valid) begin
                        req_ready_c = grant_q;
                        tx_data_d   = sel_data;
                        tx_strobe_d = 1'b1;
                        state_d     = sel_last ? ST_DRAIN : ST_HOLD;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_HOLD: begin
                // coax_tx ready lags the strobe by a cycle, so skip one look
                state_d = ST_SEND;
            end
            ST_DRAIN: begin
                // drain_q guarantees two cycles before tx_active is trusted
                drain_d = 1'b1;
                if (drain_q && !bus.tx_active) begin
                    state_d      = ST_GAP;
                    grant_d      = 2'b00;
                    last_grant_d = grant_q[1];
                    gap_d        = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.grant     = grant_q;
    assign bus.underrun  = underrun_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_strobe = tx_strobe_q;

endmodule

// File: tb/tb_coax_tx_arbiter.sv
// tb/tb_coax_tx_arbiter.sv - directed self-checking bench for coax_tx_arbiter with a coax_tx model
module tb_coax_tx_arbiter;
    import coax_pkg::*;

    localparam int GAP         = 16;
    localparam int WORD_CLOCKS = 80;

    localparam logic [COAX_WORD_WIDTH-1:0] W_A = 10'b0101110101;
    localparam logic [COAX_WORD_WIDTH-1:0] W_B = 10'b1010001110;
    localparam logic [COAX_WORD_WIDTH-1:0] W_C = 10'h155;
    localparam logic [COAX_WORD_WIDTH-1:0] W_D = 10'h2AA;
    localparam logic [COAX_WORD_WIDTH-1:0] W_E = 10'h0F0;
    localparam logic [COAX_WORD_WIDTH-1:0] W_1 = 10'h001;
    localparam logic [COAX_WORD_WIDTH-1:0] W_2 = 10'h3FF;
    localparam logic [COAX_WORD_WIDTH-1:0] W_3 = 10'h2C3;
    localparam logic [COAX_WORD_WIDTH-1:0] W_F = 10'h1E7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    coax_tx_arbiter_if bus();

    coax_tx_arbiter #(.GAP_CLOCKS(GAP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // coax_tx stand-in: 10 bits x 8 clocks per word, ready low while shifting
    int tx_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_cnt        <= 0;
            bus.tx_ready  <= 1'b1;
            bus.tx_active <= 1'b0;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) begin
                bus.tx_ready  <= 1'b1;
                bus.tx_active <= 1'b0;
            end
        end else if (bus.tx_strobe) begin
            tx_cnt        <= WORD_CLOCKS;
            bus.tx_ready  <= 1'b0;
            bus.tx_active <= 1'b1;
        end
    end

    logic [10:0]                q0[$];
    logic [10:0]                q1[$];
    logic [10:0]                h0, h1;
    bit                         en0, en1;
    logic [COAX_WORD_WIDTH-1:0] log_data[$];
    logic [1:0]                 log_grant[$];
    int                         log_cyc[$];
    logic [1:0]                 glog[$];
    logic [1:0]                 prev_grant = 2'b00;
    int                         cyc, checks, errors, underruns, n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_grant.delete();
        log_cyc.delete();
        glog.delete();
    endtask

    task automatic cycle();
        @(negedge clk);
        h0 = (q0.size() > 0) ? q0[0] : 11'd0;
        h1 = (q1.size() > 0) ? q1[0] : 11'd0;
        bus.req_valid[0] = en0 && (q0.size() > 0);
        bus.req_last[0]  = h0[10];
        bus.req_data[0]  = h0[9:0];
        bus.req_valid[1] = en1 && (q1.size() > 0);
        bus.req_last[1]  = h1[10];
        bus.req_data[1]  = h1[9:0];
        #1;
        cyc++;
        chk("ready_only_granted", 32'(bus.req_ready & ~bus.grant), 32'd0);
        chk("ready_needs_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
        chk("ready_vs_strobe", 32'((|bus.req_ready) & bus.tx_strobe), 32'd0);
        if (bus.tx_strobe) begin
            log_data.push_back(bus.tx_data);
            log_grant.push_back(bus.grant);
            log_cyc.push_back(cyc);
        end
        if (bus.underrun) underruns++;
        if (bus.grant != prev_grant && bus.grant != 2'b00) glog.push_back(bus.grant);
        prev_grant = bus.grant;
        if (bus.req_ready[0]) void'(q0.pop_front());
        if (bus.req_ready[1]) void'(q1.pop_front());
    endtask

    task automatic wait_done(input string tag, input int limit);
        n = 0;
        do begin
            cycle();
            n++;
        end while ((bus.busy || (en0 && q0.size() > 0) || (en1 && q1.size() > 0)) && n < limit);
        chk({tag, "_timeout"}, 32'(n < limit), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        underruns = 0;
        cyc = 0;
        en0 = 1'b0;
        en1 = 1'b0;

        // Reset held four cycles
        reset_n = 1'b0;
        repeat (4) cycle();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_strobe", 32'(bus.tx_strobe), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        reset_n = 1'b1;
        repeat (8) cycle();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_grant", 32'(bus.grant), 32'd0);

        // Single one-word frame from requester 0
        clear_logs();
        q0.push_back({1'b1, W_A});
        en0 = 1'b1;
        cycle();
        chk("single_c0_grant", 32'(bus.grant), 32'd0);
        cycle();
        chk("single_c1_grant", 32'(bus.grant), 32'h1);
        chk("single_c1_ready", 32'(bus.req_ready), 32'h1);
        cycle();
        chk("single_c2_strobe", 32'(bus.tx_strobe), 32'd1);
        chk("single_c2_data", 32'(bus.tx_data), 32'(W_A));
        n = 0;
        while (bus.busy && n < 500) begin
            cycle();
            n++;
        end
        chk("single_busy_clocks", 32'(n), 32'd98);
        chk("single_line_idle", 32'(bus.tx_active), 32'd0);
        chk("single_grant_clear", 32'(bus.grant), 32'd0);
        chk("single_words", 32'(log_data.size()), 32'd1);
        en0 = 1'b0;

        // Fresh reset so requester 0 wins the tie
        reset_n = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();

        // Tie: two 2-word frames presented together
        clear_logs();
        q0.push_back({1'b0, W_A});
        q0.push_back({1'b1, W_B});
        q1.push_back({1'b0, W_A});
        q1.push_back({1'b1, W_B});
        en0 = 1'b1;
        en1 = 1'b1;
        wait_done("tie", 2000);
        chk("tie_words", 32'(log_data.size()), 32'd4);
        chk("tie_w0_data", 32'(log_data[0]), 32'(W_A));
        chk("tie_w0_grant", 32'(log_grant[0]), 32'h1);
        chk("tie_w1_data", 32'(log_data[1]), 32'(W_B));
        chk("tie_w1_grant", 32'(log_grant[1]), 32'h1);
        chk("tie_w2_data", 32'(log_data[2]), 32'(W_A));
        chk("tie_w2_grant", 32'(log_grant[2]), 32'h2);
        chk("tie_w3_data", 32'(log_data[3]), 32'(W_B));
        chk("tie_w3_grant", 32'(log_grant[3]), 32'h2);
        chk("tie_gap_min", 32'((log_cyc[2] - log_cyc[1]) >= GAP), 32'd1);
        chk("tie_strobe_spacing", 32'(log_cyc[2] - log_cyc[1]), 32'd100);

        // Fairness: requester 0 has back-to-back frames, requester 1 waiting
        clear_logs();
        q0.push_back({1'b1, W_C});
        q0.push_back({1'b1, W_D});
        q1.push_back({1'b1, W_E});
        wait_done("fair", 2000);
        chk("fair_grants", 32'(glog.size()), 32'd3);
        chk("fair_g0", 32'(glog[0]), 32'h1);
        chk("fair_g1", 32'(glog[1]), 32'h2);
        chk("fair_g2", 32'(glog[2]), 32'h1);
        chk("fair_d0", 32'(log_data[0]), 32'(W_C));
        chk("fair_d1", 32'(log_data[1]), 32'(W_E));
        chk("fair_d2", 32'(log_data[2]), 32'(W_D));

        // Underrun: requester 1 drops valid after its first of three words
        clear_logs();
        underruns = 0;
        en0 = 1'b0;
        q1.push_back({1'b0, W_1});
        q1.push_back({1'b0, W_2});
        q1.push_back({1'b1, W_3});
        n = 0;
        while (q1.size() != 2 && n < 50) begin
            cycle();
            n++;
        end
        chk("ur_first_taken", 32'(q1.size()), 32'd2);
        en1 = 1'b0;
        wait_done("ur_drain", 500);
        chk("ur_pulses", 32'(underruns), 32'd1);
        chk("ur_words", 32'(log_data.size()), 32'd1);
        chk("ur_w0_data", 32'(log_data[0]), 32'(W_1));
        chk("ur_w0_grant", 32'(log_grant[0]), 32'h2);
        chk("ur_left", 32'(q1.size()), 32'd2);
        chk("ur_idle", 32'(bus.busy), 32'd0);
        en1 = 1'b1;
        wait_done("ur_resume", 1000);
        chk("ur_resume_words", 32'(log_data.size()), 32'd3);
        chk("ur_resume_last", 32'(log_data[2]), 32'(W_3));
        chk("ur_resume_pulses", 32'(underruns), 32'd1);

        // Reset asserted during HOLD
        clear_logs();
        en1 = 1'b0;
        q0.push_back({1'b0, W_A});
        q0.push_back({1'b1, W_B});
        en0 = 1'b1;
        repeat (3) cycle();
        chk("mid_pre_strobe", 32'(bus.tx_strobe), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_strobe_drop", 32'(bus.tx_strobe), 32'd0);
        chk("mid_grant_drop", 32'(bus.grant), 32'd0);
        chk("mid_busy_drop", 32'(bus.busy), 32'd0);
        q0.delete();
        en0 = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        clear_logs();
        q1.push_back({1'b1, W_F});
        en1 = 1'b1;
        wait_done("post_rst", 500);
        chk("post_rst_words", 32'(log_data.size()), 32'd1);
        chk("post_rst_data", 32'(log_data[0]), 32'(W_F));
        chk("post_rst_grant", 32'(log_grant[0]), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
